sdr_fetch_arbiter: RTL and testbench
====================================

SDR_FETCH_ARBITER -- requirements
Module: sdr_fetch_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 3, number of requesters; port 0 = sprite fetch, 1 = tile fetch, 2 = CPU ROM.
REQ-002 Parameter ADDR_W, default 25, SDRAM word address width.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 port_addr  in  [NUM_PORTS-1:0][ADDR_W-1:0]  per-port address, sampled with port_req.
REQ-006 port_req  in  [NUM_PORTS-1:0]  one-cycle request pulse per port.
REQ-007 port_refresh  in  [NUM_PORTS-1:0]  per-port "refresh allowed now" hint.
REQ-008 port_data  out  [63:0]  shared read data; valid on port_rdy cycle.
REQ-009 port_rdy  out  [NUM_PORTS-1:0]  one-cycle completion pulse to owning port.
REQ-010 port_ovf  out  [NUM_PORTS-1:0]  sticky flag: request dropped on that port.
REQ-011 sdr_addr  out  ADDR_W  downstream address, held stable from issue until completion.
REQ-012 sdr_req  out  1  one-cycle downstream request pulse.
REQ-013 sdr_rdy  in  1  one-cycle downstream completion pulse.
REQ-014 sdr_data  in  64  downstream data, valid with sdr_rdy.
REQ-015 sdr_refresh  out  1  refresh permission to SDRAM controller.

Function
REQ-016 Each port has one pending slot; port_req with slot empty latches port_addr and sets pending at the same edge.
REQ-017 port_req while that port's slot is pending or granted: request dropped, port_ovf bit set; existing request unaffected.
REQ-018 States IDLE, WAIT; IDLE with any pending: grant selected port, sdr_addr <= latched address, sdr_req=1 for one cycle, clear that pending bit, go WAIT.
REQ-019 IDLE with nothing pending: remain IDLE, sdr_req=0.
REQ-020 WAIT: sdr_rdy high -> port_data <= sdr_data, port_rdy[grant]=1 next cycle only, go IDLE; otherwise hold, no timeout.
REQ-021 Latency: port_req at edge E -> sdr_req high after edge E+1; sdr_rdy at edge F -> port_rdy high after edge F; earliest next sdr_req after edge F+1.
REQ-022 port_req on the granted port sampled at the same edge as sdr_rdy: completion delivered and new request latched (slot freed first).
REQ-023 sdr_rdy in IDLE is ignored (no port_rdy, no state change).
REQ-024 sdr_refresh=1 only in IDLE with no pending and all port_refresh bits high; registered, one-cycle latency.
REQ-025 sdr_refresh and sdr_req never high in the same cycle.
REQ-026 Grant index width = clog2(NUM_PORTS); ports >= NUM_PORTS never granted.

Reset
REQ-027 Reset clears pending, port_ovf, port_rdy, sdr_req, sdr_refresh; sdr_addr=0, port_data=0, grant=0, state IDLE, rotation pointer=0.
REQ-028 Reset during WAIT abandons the transaction; its late sdr_rdy is ignored per REQ-023; no port_rdy issued.
REQ-029 port_req asserted in the reset cycle is not latched.

Configuration
REQ-030 Macro SDR_ARB_ROUND_ROBIN_EN defined: round-robin; search starts at port after last grant, pointer updates on each grant.
REQ-031 Macro undefined: fixed priority, lowest index wins (sprite highest); rotation pointer absent.

Structure
REQ-032 m107_pkg holds arb state enum and port index constants PORT_OBJ=0, PORT_TILE=1, PORT_CPU=2.
REQ-033 One sub-module arb_pick: combinational pick of pending vector and start index -> grant index plus valid; no other sub-modules.

Verification
REQ-034 Single: port1 req addr 0x0123456, sdr_rdy 5 cycles after sdr_req with data 0xDEADBEEF_CAFEF00D -> sdr_addr=0x0123456, port_rdy=3'b010, port_data matches.
REQ-035 Simultaneous req ports 0,1,2 same edge, fixed priority -> grant order 0,1,2; round robin after last grant 0 -> order 1,2,0.
REQ-036 Port0 req twice while pending -> one sdr_req for port0, port_ovf=3'b001, sticky until reset.
REQ-037 Reset asserted 2 cycles after sdr_req, stale sdr_rdy 3 cycles later -> no port_rdy, state IDLE, all outputs at reset values.
REQ-038 All port_refresh=1, no pending -> sdr_refresh=1; port2 req arrives -> sdr_refresh=0 before sdr_req, never coincident.

Source files
------------

// File: rtl/m107_pkg.sv
// Shared types and constants for sdr_fetch_arbiter and its arb_pick helper.
package m107_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    localparam int PORT_OBJ  = 0;
    localparam int PORT_TILE = 1;
    localparam int PORT_CPU  = 2;

    // Index width that stays legal for a single-port build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdr_fetch_arbiter_pick.sv
// arb_pick: combinational search of the pending vector starting at a given index.
module arb_pick
    import m107_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] pending,
    input  logic [IDX_W-1:0]     start,
    output logic [IDX_W-1:0]     idx,
    output logic                 valid
);

    always_comb begin
        int cand;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        // Walk NUM_PORTS slots from start with wrap; the first pending one wins.
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = int'(start) + k;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!valid && pending[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sdr_fetch_arbiter.sv
// sdr_fetch_arbiter: shares one SDRAM read channel between sprite, tile and CPU fetch ports.
// Define SDR_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module sdr_fetch_arbiter
    import m107_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 25
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  port_addr,
    input  logic [NUM_PORTS-1:0]              port_req,
    input  logic [NUM_PORTS-1:0]              port_refresh,
    output logic [63:0]                       port_data,
    output logic [NUM_PORTS-1:0]              port_rdy,
    output logic [NUM_PORTS-1:0]              port_ovf,
    output logic [ADDR_W-1:0]                 sdr_addr,
    output logic                              sdr_req,
    input  logic                              sdr_rdy,
    input  logic [63:0]                       sdr_data,
    output logic                              sdr_refresh
);

    localparam int IDX_W = idx_width(NUM_PORTS);
    typedef logic [IDX_W-1:0] idx_t;

    arb_state_t                       state_q, state_d;
    logic [NUM_PORTS-1:0]             pending_q, pending_d;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic [NUM_PORTS-1:0]             ovf_q, ovf_d;
    logic [NUM_PORTS-1:0]             port_rdy_q, port_rdy_d;
    logic [63:0]                      port_data_q, port_data_d;
    logic [ADDR_W-1:0]                sdr_addr_q, sdr_addr_d;
    logic                             sdr_req_q, sdr_req_d;
    logic                             refresh_q, refresh_d;
    idx_t                             grant_q, grant_d;
    idx_t                             pick_start, pick_idx;
    logic                             pick_vld;
    logic                             grant_fire;
    logic                             complete;

`ifdef SDR_ARB_ROUND_ROBIN_EN
    idx_t rr_ptr_q, rr_ptr_d;
    assign pick_start = rr_ptr_q;
`else
    assign pick_start = idx_t'(PORT_OBJ);
`endif

    arb_pick #(
        .NUM_PORTS(NUM_PORTS),
        .IDX_W    (IDX_W)
    ) u_pick (
        .pending(pending_q),
        .start  (pick_start),
        .idx    (pick_idx),
        .valid  (pick_vld)
    );

    assign grant_fire = (state_q == ARB_IDLE) && pick_vld;
    assign complete   = (state_q == ARB_WAIT) && sdr_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            pending_q   <= '0;
            ovf_q       <= '0;
            port_rdy_q  <= '0;
            port_data_q <= '0;
            sdr_addr_q  <= '0;
            sdr_req_q   <= 1'b0;
            refresh_q   <= 1'b0;
            grant_q     <= '0;
`ifdef SDR_ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            port_rdy_q  <= port_rdy_d;
            port_data_q <= port_data_d;
            sdr_addr_q  <= sdr_addr_d;
            sdr_req_q   <= sdr_req_d;
            refresh_q   <= refresh_d;
            grant_q     <= grant_d;
`ifdef SDR_ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    // Slot addresses are only meaningful while pending, so they carry no reset.
    always_ff @(posedge clk) begin
        slot_addr_q <= slot_addr_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (pick_vld) state_d = ARB_WAIT;
            ARB_WAIT: if (sdr_rdy)  state_d = ARB_IDLE;
            default:                state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        logic busy;
        pending_d   = pending_q;
        slot_addr_d = slot_addr_q;
        ovf_d       = ovf_q;
        port_rdy_d  = '0;
        port_data_d = port_data_q;
        sdr_addr_d  = sdr_addr_q;
        sdr_req_d   = 1'b0;
        grant_d     = grant_q;
        busy        = 1'b0;
`ifdef SDR_ARB_ROUND_ROBIN_EN
        rr_ptr_d    = rr_ptr_q;
`endif

        if (grant_fire) begin
            pending_d[pick_idx] = 1'b0;
            grant_d             = pick_idx;
            sdr_addr_d          = slot_addr_q[pick_idx];
            sdr_req_d           = 1'b1;
`ifdef SDR_ARB_ROUND_ROBIN_EN
            rr_ptr_d = (pick_idx == idx_t'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
`endif
        end

        if (complete) begin
            port_data_d         = sdr_data;
            port_rdy_d[grant_q] = 1'b1;
        end

        // A completing transaction frees its port's slot before new requests are judged.
        for (int i = 0; i < NUM_PORTS; i++) begin
            busy = pending_q[i] ||
                   ((state_q == ARB_WAIT) && (grant_q == idx_t'(i)) && !sdr_rdy);
            if (port_req[i]) begin
                if (busy) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pending_d[i]   = 1'b1;
                    slot_addr_d[i] = port_addr[i];
                end
            end
        end

        // Looking ahead at next-cycle state drops refresh one cycle before any sdr_req.
        refresh_d = (state_d == ARB_IDLE) && (pending_d == '0) && (&port_refresh) && !sdr_req_d;
    end

    assign port_data   = port_data_q;
    assign port_rdy    = port_rdy_q;
    assign port_ovf    = ovf_q;
    assign sdr_addr    = sdr_addr_q;
    assign sdr_req     = sdr_req_q;
    assign sdr_refresh = refresh_q;

endmodule

// File: tb/tb_sdr_fetch_arbiter.sv
// Scoreboard bench for sdr_fetch_arbiter: stimulus queues expectations, a monitor checks outputs.
module tb_sdr_fetch_arbiter;

    localparam int NP = 3;
    localparam int AW = 25;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NP-1:0][AW-1:0]  port_addr;
    logic [NP-1:0]          port_req;
    logic [NP-1:0]          port_refresh;
    logic [63:0]            port_data;
    logic [NP-1:0]          port_rdy;
    logic [NP-1:0]          port_ovf;
    logic [AW-1:0]          sdr_addr;
    logic                   sdr_req;
    logic                   sdr_rdy;
    logic [63:0]            sdr_data;
    logic                   sdr_refresh;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [NP-1:0] exp_rdy_q[$];
    logic [63:0]   exp_data_q[$];
    logic [63:0]   resp_data_q[$];
    bit            resp_en = 1'b1;

    sdr_fetch_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .port_addr   (port_addr),
        .port_req    (port_req),
        .port_refresh(port_refresh),
        .port_data   (port_data),
        .port_rdy    (port_rdy),
        .port_ovf    (port_ovf),
        .sdr_addr    (sdr_addr),
        .sdr_req     (sdr_req),
        .sdr_rdy     (sdr_rdy),
        .sdr_data    (sdr_data),
        .sdr_refresh (sdr_refresh)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input int p, input logic [AW-1:0] a, input logic [63:0] d);
        logic [NP-1:0] oh;
        oh    = '0;
        oh[p] = 1'b1;
        exp_addr_q.push_back(a);
        exp_rdy_q.push_back(oh);
        exp_data_q.push_back(d);
        resp_data_q.push_back(d);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_addr_q.size() != 0 || exp_rdy_q.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        check(name, (n < 300), 1);
        @(posedge clk); #1;
    endtask

    // Downstream model: answers each sdr_req with sdr_rdy five cycles later.
    initial begin
        sdr_rdy  = 1'b0;
        sdr_data = '0;
        forever begin
            @(posedge clk); #1;
            if (resp_en && sdr_req === 1'b1) begin
                repeat (5) @(posedge clk);
                #1;
                sdr_rdy  = 1'b1;
                sdr_data = (resp_data_q.size() != 0) ? resp_data_q.pop_front() : 64'h0;
                @(posedge clk); #1;
                sdr_rdy  = 1'b0;
            end
        end
    end

    // Monitor: every sdr_req and port_rdy must match the head of its queue.
    initial begin
        forever begin
            @(negedge clk);
            if (sdr_req === 1'b1) begin
                check("req_refresh_exclusive", sdr_refresh, 0);
                if (exp_addr_q.size() == 0) check("unexpected_sdr_req", 1, 0);
                else                        check("sdr_addr", sdr_addr, exp_addr_q.pop_front());
            end
            if (port_rdy !== '0 && port_rdy !== 'x) begin
                if (exp_rdy_q.size() == 0) begin
                    check("unexpected_port_rdy", port_rdy, 0);
                end else begin
                    check("port_rdy", port_rdy, exp_rdy_q.pop_front());
                    check("port_data", port_data, exp_data_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        reset        = 1'b1;
        port_req     = '1;
        port_addr    = '0;
        port_refresh = '0;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        port_req = '0;

        // Reset values; requests present during reset must not be latched.
        @(negedge clk);
        check("rst_sdr_req", sdr_req, 0);
        check("rst_port_rdy", port_rdy, 0);
        check("rst_port_ovf", port_ovf, 0);
        check("rst_sdr_addr", sdr_addr, 0);
        check("rst_port_data", port_data, 0);
        check("rst_sdr_refresh", sdr_refresh, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_no_latched_req", sdr_req, 0);
        @(posedge clk); #1;

        // Single transaction on the tile port with latency checks.
        expect_txn(1, 25'h0123456, 64'hDEADBEEF_CAFEF00D);
        port_addr[1] = 25'h0123456;
        port_req     = 3'b010;
        @(posedge clk); #1;
        port_req = '0;
        @(negedge clk);
        check("lat_req_not_yet", sdr_req, 0);
        @(negedge clk);
        check("lat_req_edge_plus1", sdr_req, 1);
        drain("single_done");

        // Port 0 alone leaves the last grant at 0.
        expect_txn(0, 25'h0000001, 64'h0000_0000_0000_0001);
        port_addr[0] = 25'h0000001;
        port_req     = 3'b001;
        @(posedge clk); #1;
        port_req = '0;
        drain("port0_done");

        // Three simultaneous requests.
`ifdef SDR_ARB_ROUND_ROBIN_EN
        expect_txn(1, 25'h0ABCDEF, 64'h1111_1111_1111_1111);
        expect_txn(2, 25'h1FFFFFF, 64'h2222_2222_2222_2222);
        expect_txn(0, 25'h1000000, 64'h3333_3333_3333_3333);
`else
        expect_txn(0, 25'h1000000, 64'h1111_1111_1111_1111);
        expect_txn(1, 25'h0ABCDEF, 64'h2222_2222_2222_2222);
        expect_txn(2, 25'h1FFFFFF, 64'h3333_3333_3333_3333);
`endif
        port_addr[0] = 25'h1000000;
        port_addr[1] = 25'h0ABCDEF;
        port_addr[2] = 25'h1FFFFFF;
        port_req     = 3'b111;
        @(posedge clk); #1;
        port_req = '0;
        drain("simultaneous_done");

        // Repeat requests on port 0 while pending and while granted are dropped.
        expect_txn(0, 25'h0000055, 64'h0123_4567_89AB_CDEF);
        port_addr[0] = 25'h0000055;
        port_req     = 3'b001;
        @(posedge clk); #1;
        port_addr[0] = 25'h0000066;
        @(posedge clk); #1;
        port_req = '0;
        @(posedge clk); #1;
        port_addr[0] = 25'h0000077;
        port_req     = 3'b001;
        @(posedge clk); #1;
        port_req = '0;
        @(negedge clk);
        check("ovf_set", port_ovf, 3'b001);
        drain("ovf_done");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ovf_sticky", port_ovf, 3'b001);
        @(posedge clk); #1;

        // New request on the granted port at the same edge as sdr_rdy.
        expect_txn(1, 25'h0AAAAAA, 64'hAAAA_0000_AAAA_0000);
        expect_txn(1, 25'h1555555, 64'h5555_0000_5555_0000);
        port_addr[1] = 25'h0AAAAAA;
        port_req     = 3'b010;
        @(posedge clk); #1;
        port_req = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sdr_rdy !== 1'b1 && n < 50);
        check("wait_sdr_rdy", (n < 50), 1);
        port_addr[1] = 25'h1555555;
        port_req     = 3'b010;
        @(posedge clk); #1;
        port_req = '0;
        @(negedge clk);
        check("same_edge_no_ovf", port_ovf, 3'b001);
        drain("same_edge_done");

        // Refresh permission while idle, withdrawn ahead of a new request.
        port_refresh = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("refresh_idle", sdr_refresh, 1);
        @(posedge clk); #1;
        expect_txn(2, 25'h0000ABC, 64'hFEED_FACE_0000_0002);
        port_addr[2] = 25'h0000ABC;
        port_req     = 3'b100;
        @(posedge clk); #1;
        port_req = '0;
        @(negedge clk);
        check("refresh_dropped", sdr_refresh, 0);
        check("refresh_req_not_yet", sdr_req, 0);
        @(negedge clk);
        check("refresh_then_req", sdr_req, 1);
        drain("refresh_done");
        port_refresh = '0;

        // Reset during WAIT, then a stale sdr_rdy.
        resp_en = 1'b0;
        exp_addr_q.push_back(25'h1F0F0F0);
        port_addr[2] = 25'h1F0F0F0;
        port_req     = 3'b100;
        @(posedge clk); #1;
        port_req = '0;
        @(negedge clk);
        @(negedge clk);
        check("abort_req_issued", sdr_req, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sdr_rdy  = 1'b1;
        sdr_data = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk); #1;
        sdr_rdy  = 1'b0;
        @(negedge clk);
        check("abort_port_rdy", port_rdy, 0);
        check("abort_port_ovf", port_ovf, 0);
        check("abort_sdr_addr", sdr_addr, 0);
        check("abort_port_data", port_data, 0);
        check("abort_sdr_req", sdr_req, 0);
        check("abort_sdr_refresh", sdr_refresh, 0);
        @(posedge clk); #1;
        resp_en = 1'b1;

        // Arbiter must be back in IDLE and serve a fresh request.
        expect_txn(1, 25'h0001234, 64'hC0DE_C0DE_0000_1234);
        port_addr[1] = 25'h0001234;
        port_req     = 3'b010;
        @(posedge clk); #1;
        port_req = '0;
        drain("after_abort_done");

        repeat (5) @(posedge clk);
        check("queues_empty", exp_addr_q.size() + exp_rdy_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
